led_mode_sequencer: RTL and testbench
=====================================

LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter DWELL_TICKS, default 25_000_000, clock cycles each mode is held in auto mode (1 s at 25 MHz); the minimum is 2.
REQ-002 Parameter DEBOUNCE_TICKS, default 250_000, cycles the button must be stable to register (10 ms at 25 MHz); the minimum is 2.
REQ-003 i_clock  in  1  sole clock; all state SHALL be on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  synchronous level; sampled high in IDLE starts the sequence.
REQ-006 i_stop  in  1  synchronous level; sampled high returns the block to IDLE.
REQ-007 i_auto  in  1  synchronous level; 1 = timed auto-advance, 0 = manual advance only.
REQ-008 i_button  in  1  raw asynchronous push-button, active-high.
REQ-009 o_enable  out  1  drives the blinker enable input.
REQ-010 o_switch_1  out  1  drives blinker switch 1, and SHALL equal o_mode[1].
REQ-011 o_switch_2  out  1  drives blinker switch 2, and SHALL equal o_mode[0].
REQ-012 o_mode  out  2  current blink-rate mode, 0..3.
REQ-013 o_busy  out  1  high while in RUN.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN.
REQ-015 IDLE behaviour: o_enable=0, o_busy=0, o_mode=0, and the dwell counter is held at 0.
REQ-016 IDLE->RUN transition: on a clock edge where i_start=1 and i_stop=0.
  - On that edge, o_enable and o_busy SHALL go to 1.
  - On that edge, o_mode stays 0 and the dwell counter clears.
REQ-017 RUN->IDLE transition: on any edge where i_stop=1.
  - On that edge, o_mode SHALL go to 0 and o_enable to 0.
  - i_stop SHALL win over i_start, the button and dwell expiry on the same edge.
REQ-018 Dwell counter (RUN with i_auto=1):
  - It SHALL count 0..DWELL_TICKS-1.
  - On the edge where it equals DWELL_TICKS-1, o_mode SHALL increment and the counter SHALL clear.
  - Each mode is therefore held exactly DWELL_TICKS cycles.
REQ-019 In RUN with i_auto=0, the dwell counter SHALL hold its value, and resume from that value when i_auto returns to 1.
REQ-020 Button advance: a debounced button rising-edge pulse in RUN SHALL increment o_mode on the next edge and clear the dwell counter, in both auto and manual modes.
REQ-021 If a button pulse and dwell expiry coincide, o_mode SHALL advance by exactly one and the counter SHALL clear.
REQ-022 o_mode increments modulo 4 (3 -> 0), with no carry out.
REQ-023 Button pulses in IDLE SHALL be discarded; they neither start the sequence nor change the mode.
REQ-024 Button path:
  - i_button SHALL pass through a 2-flop synchronizer.
  - The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_TICKS consecutive cycles.
  - Any bounce restarts the count.
  - One press yields exactly one 1-cycle pulse.
REQ-025 Holding the button indefinitely SHALL produce no auto-repeat.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-027 Counter widths SHALL be $clog2(DWELL_TICKS) and $clog2(DEBOUNCE_TICKS+1), with no overflow at the maxima.

Reset
REQ-028 While i_reset=1, all of the following SHALL hold:
  - the FSM is in IDLE;
  - o_enable=0, o_busy=0, o_mode=0, o_switch_1=0, o_switch_2=0;
  - the dwell counter, debounce counter, synchronizer flops and debounced level are all 0.
REQ-029 Reset asserted mid-RUN SHALL take effect asynchronously without waiting for a clock edge.
REQ-030 After reset deasserts, the block SHALL remain in IDLE until i_start is sampled high.

Structure
REQ-031 The FSM state encoding and the mode constants (MODE_0..MODE_3) SHALL live in a shared package, led_ctrl_pkg.
REQ-032 The synchronizer and debouncer SHALL be a sub-module, button_debounce.
  - Ports: clock, reset, raw input, debounced level, rising pulse.
  - It takes the DEBOUNCE_TICKS parameter.
REQ-033 The top level SHALL contain only the FSM, the dwell counter and the mode register.

Verification (DWELL_TICKS=8, DEBOUNCE_TICKS=4)
REQ-034 Reset during RUN at o_mode=2 -> all outputs 0 immediately, before the next clock edge.
REQ-035 i_auto=1, start pulse -> o_mode sequence 0,1,2,3,0, each value held exactly 8 cycles; o_enable=1 throughout.
REQ-036 i_auto=0, raw button bouncing 1,0,1 (1 cycle each), then held high for 10 cycles -> exactly one advance, o_mode 0->1.
REQ-037 i_auto=1; button pulse lands on dwell cycle 7 -> o_mode advances by 1 only, and the next advance occurs 8 cycles later.
REQ-038 i_start and i_stop high together in IDLE -> remains IDLE; i_stop in RUN at o_mode=3 -> o_mode=0 and o_enable=0 on the next edge.
REQ-039 Button press while in IDLE, then start -> o_mode=0 after start (the press is discarded).

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED mode sequencer: FSM encoding and blink-rate modes.
package led_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  // Mode wraps 3 -> 0 by truncation to two bits.
  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    return mode + 2'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer and counting debouncer for a raw push-button; emits one
// single-cycle pulse on each debounced rising edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 250_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;

  // Level flips on the DEBOUNCE_TICKS-th consecutive differing sample; any
  // agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_level = level_q;
  assign o_pulse = pulse_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Steps a blinker through four blink-rate modes, either on a dwell timer or on
// debounced button presses, between start and stop commands.
module led_mode_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_TICKS    = 25_000_000,
  parameter int unsigned DEBOUNCE_TICKS = 250_000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_auto,
  input  logic       i_button,
  output logic       o_enable,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic [1:0] o_mode,
  output logic       o_busy
);

  localparam int unsigned DwellW = $clog2(DWELL_TICKS);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_TICKS - 1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic              btn_pulse;
  logic              unused_btn_level;

  button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_button_debounce (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_raw  (i_button),
    .o_level(unused_btn_level),
    .o_pulse(btn_pulse)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    unique case (state_q)
      StIdle: begin
        mode_d  = MODE_0;
        dwell_d = '0;
        if (i_start && !i_stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Stop dominates; a press coinciding with dwell expiry advances once.
        if (i_stop) begin
          state_d = StIdle;
          mode_d  = MODE_0;
          dwell_d = '0;
        end else if (btn_pulse || (i_auto && dwell_q == DwellLast)) begin
          mode_d  = next_mode(mode_q);
          dwell_d = '0;
        end else if (i_auto) begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      mode_q  <= MODE_0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
    end
  end

  assign o_enable   = (state_q == StRun);
  assign o_busy     = (state_q == StRun);
  assign o_mode     = mode_q;
  assign o_switch_1 = mode_q[1];
  assign o_switch_2 = mode_q[0];

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with DWELL_TICKS=8, DEBOUNCE_TICKS=4.
module tb_led_mode_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       auto_mode;
  logic       button;
  logic       enable;
  logic       switch_1;
  logic       switch_2;
  logic [1:0] mode;
  logic       busy;

  int checks;
  int failures;

  led_mode_sequencer #(
    .DWELL_TICKS   (8),
    .DEBOUNCE_TICKS(4)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_start   (start),
    .i_stop    (stop),
    .i_auto    (auto_mode),
    .i_button  (button),
    .o_enable  (enable),
    .o_switch_1(switch_1),
    .o_switch_2(switch_2),
    .o_mode    (mode),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_enable"}, 32'(enable), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_mode"}, 32'(mode), 0);
    check_eq({tag, "_sw1"}, 32'(switch_1), 0);
    check_eq({tag, "_sw2"}, 32'(switch_2), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  int changes;
  logic [1:0] prev_mode;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    auto_mode = 1'b0;
    button    = 1'b0;

    // Reset state and staying idle afterwards.
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    repeat (3) tick();
    check_idle("post_reset");

    // Start and stop together in IDLE: stays idle.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_idle("start_stop_idle");

    // Press in IDLE is discarded.
    button = 1'b1;
    repeat (12) tick();
    check_idle("idle_press");
    button = 1'b0;
    repeat (12) tick();
    auto_mode = 1'b0;
    do_start();
    check_eq("idle_press_busy", 32'(busy), 1);
    check_eq("idle_press_mode", 32'(mode), 0);
    repeat (3) tick();
    check_eq("idle_press_mode_later", 32'(mode), 0);
    do_stop();
    check_idle("stop_manual");

    // Auto sequence 0,1,2,3,0 with 8 cycles per mode.
    auto_mode = 1'b1;
    do_start();
    check_eq("auto_k0_mode", 32'(mode), 0);
    check_eq("auto_k0_enable", 32'(enable), 1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check_eq($sformatf("auto_k%0d_mode", k), 32'(mode), 32'((k / 8) % 4));
      check_eq($sformatf("auto_k%0d_enable", k), 32'(enable), 1);
    end
    do_stop();
    check_idle("stop_auto");

    // Stop at mode 3 (with start also high) returns to mode 0 on the next edge.
    do_start();
    repeat (24) tick();
    check_eq("pre_stop_mode3", 32'(mode), 3);
    check_eq("pre_stop_sw", 32'({switch_1, switch_2}), 3);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_idle("stop_mode3");

    // Button pulse coincides with dwell expiry: a single advance.
    // Raw set after edge k=1 reaches the FSM as a pulse at edge k=8.
    do_start();
    tick();
    button = 1'b1;
    for (int k = 2; k <= 24; k++) begin
      tick();
      check_eq($sformatf("coinc_k%0d_mode", k), 32'(mode),
               (k < 8) ? 0 : (k < 16) ? 1 : (k < 24) ? 2 : 3);
    end
    button = 1'b0;
    do_stop();
    repeat (12) tick();
    check_idle("coinc_after");

    // Manual mode, bouncing press then held: exactly one advance.
    auto_mode = 1'b0;
    do_start();
    changes   = 0;
    prev_mode = mode;
    button = 1'b1;
    tick();
    if (mode != prev_mode) changes++;
    prev_mode = mode;
    button = 1'b0;
    tick();
    if (mode != prev_mode) changes++;
    prev_mode = mode;
    button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mode != prev_mode) changes++;
      prev_mode = mode;
    end
    button = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mode != prev_mode) changes++;
      prev_mode = mode;
    end
    check_eq("bounce_adv_count", 32'(changes), 1);
    check_eq("bounce_mode", 32'(mode), 1);
    check_eq("bounce_sw2", 32'(switch_2), 1);
    do_stop();

    // Asynchronous reset mid-run at mode 2.
    auto_mode = 1'b1;
    do_start();
    repeat (17) tick();
    check_eq("pre_reset_mode2", 32'(mode), 2);
    check_eq("pre_reset_sw1", 32'(switch_1), 1);
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_idle("after_async_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
